// File: rtl/tdc_merge_fifo_pkg.sv
// rtl/tdc_merge_fifo_pkg.sv - shared widths, FSM encoding and counter sizing for the TDC merge stage
package tdc_merge_fifo_pkg;

    localparam int TDC_FINE_W   = 16;
    localparam int TDC_COARSE_W = 8;
    localparam int TDC_OUT_W    = TDC_COARSE_W + 2 * TDC_FINE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_PUSH   = 2'd3
    } state_t;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tdc_merge_fifo_if.sv
// rtl/tdc_merge_fifo_if.sv - valid/ready result stream carrying merged TDC words
interface tdc_merge_fifo_if
    import tdc_merge_fifo_pkg::*;
#(
    parameter int W = TDC_OUT_W
) ();

    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/tdc_sync_fifo.sv
// rtl/tdc_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module tdc_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill  = wr_ptr - rd_ptr;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Head is forced to zero when empty so stale storage never leaks out.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/tdc_merge_fifo.sv
// rtl/tdc_merge_fifo.sv - captures start/stop/coarse, waits a settle time, queues merged words
module tdc_merge_fifo
    import tdc_merge_fifo_pkg::*;
#(
    parameter int W_FINE      = TDC_FINE_W,
    parameter int W_COARSE    = TDC_COARSE_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_start,
    input  logic                     store_stop,
    input  logic [W_FINE-1:0]        start_code,
    input  logic [W_FINE-1:0]        stop_code,
    input  logic [W_COARSE-1:0]      coarse,
    tdc_merge_fifo_if.master         m,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic                     overflow
);

    localparam int W_OUT = W_COARSE + 2 * W_FINE;
    localparam int SCW   = cnt_width(SETTLE_CYC);
    localparam int TCW   = cnt_width(TIMEOUT_CYC);
    localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYC - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYC - 1);

    state_t                state;
    logic [SCW-1:0]        settle_cnt;
    logic [TCW-1:0]        tmo_cnt;
    logic [W_FINE-1:0]     start_q;
    logic [W_FINE-1:0]     stop_q;
    logic [W_COARSE-1:0]   coarse_q;

    logic                  fifo_wr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [W_OUT-1:0]      fifo_rdata;
    logic                  valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            coarse_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A lone stop has no start to pair with and is dropped.
                    if (store_start) begin
                        start_q <= start_code;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        if (store_stop) begin
                            stop_q     <= stop_code;
                            coarse_q   <= coarse;
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    // Stop is checked first so it wins against an expiring timeout.
                    if (store_stop) begin
                        stop_q     <= stop_code;
                        coarse_q   <= coarse;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_PUSH;
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
                ST_PUSH: begin
                    // done still pulses for a dropped word so the TDC chain gets reset.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Fullness comes from registered pointers, so a same-cycle pop cannot make room.
    assign fifo_wr = (state == ST_PUSH) && !fifo_full;
    assign valid   = !fifo_empty;
    assign fifo_rd = valid && m.m_ready;

    tdc_sync_fifo #(
        .WIDTH (W_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({coarse_q, start_q, stop_q}),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .fill    (fill)
    );

    assign m.m_data  = fifo_rdata;
    assign m.m_valid = valid;

endmodule

// File: tb/tb_tdc_merge_fifo.sv
// tb/tb_tdc_merge_fifo.sv - directed and randomized checks of tdc_merge_fifo against a queue-based model
module tb_tdc_merge_fifo;

    localparam int W_FINE   = 16;
    localparam int W_COARSE = 8;
    localparam int SETTLE   = 4;
    localparam int TMO      = 10;
    localparam int DEPTH    = 8;
    localparam int W_OUT    = W_COARSE + 2 * W_FINE;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                store_start = 1'b0;
    logic                store_stop = 1'b0;
    logic [W_FINE-1:0]   start_code = '0;
    logic [W_FINE-1:0]   stop_code = '0;
    logic [W_COARSE-1:0] coarse = '0;
    logic [3:0]          fill;
    logic                busy;
    logic                done;
    logic                timeout;
    logic                overflow;

    int n_cmp = 0;
    int n_bad = 0;

    tdc_merge_fifo_if #(.W(W_OUT)) m_if ();

    tdc_merge_fifo #(
        .W_FINE      (W_FINE),
        .W_COARSE    (W_COARSE),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .store_start (store_start),
        .store_stop  (store_stop),
        .start_code  (start_code),
        .stop_code   (stop_code),
        .coarse      (coarse),
        .m           (m_if),
        .fill        (fill),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: a measurement is either waiting for stop (deadline in edges)
    // or scheduled to land in the queue at a known edge.
    logic [W_OUT-1:0]    q[$];
    bit                  armed = 0;
    bit                  settling = 0;
    bit                  model_live = 0;
    bit                  was_full;
    int                  edge_n = 0;
    int                  arm_edge = 0;
    int                  push_edge = 0;
    logic [W_FINE-1:0]   ms = '0;
    logic [W_FINE-1:0]   mp = '0;
    logic [W_COARSE-1:0] mc = '0;
    bit                  e_done = 0;
    bit                  e_tmo = 0;
    bit                  e_ovf = 0;

    always @(posedge clk) begin
        edge_n++;
        e_done = 0;
        e_tmo  = 0;
        if (rst) begin
            q.delete();
            armed      = 0;
            settling   = 0;
            e_ovf      = 0;
            model_live = 1;
        end else begin
            was_full = (q.size() == DEPTH);
            if (q.size() > 0 && m_if.m_ready) void'(q.pop_front());
            if (settling) begin
                if (edge_n == push_edge) begin
                    settling = 0;
                    e_done   = 1;
                    if (was_full) e_ovf = 1;
                    else q.push_back({mc, ms, mp});
                end
            end else if (armed) begin
                if (store_stop) begin
                    mp        = stop_code;
                    mc        = coarse;
                    armed     = 0;
                    settling  = 1;
                    push_edge = edge_n + SETTLE + 1;
                end else if (edge_n == arm_edge + TMO) begin
                    armed = 0;
                    e_tmo = 1;
                end
            end else if (store_start) begin
                ms = start_code;
                if (store_stop) begin
                    mp        = stop_code;
                    mc        = coarse;
                    settling  = 1;
                    push_edge = edge_n + SETTLE + 1;
                end else begin
                    armed    = 1;
                    arm_edge = edge_n;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("m_valid",  m_if.m_valid, q.size() > 0);
            check("m_data",   m_if.m_data, (q.size() > 0) ? q[0] : '0);
            check("fill",     fill, q.size());
            check("busy",     busy, armed || settling);
            check("done",     done, e_done);
            check("timeout",  timeout, e_tmo);
            check("overflow", overflow, e_ovf);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input bit s, input bit p, input logic [15:0] sc,
                          input logic [15:0] pc, input logic [7:0] cc);
        store_start = s;
        store_stop  = p;
        start_code  = sc;
        stop_code   = pc;
        coarse      = cc;
    endtask

    task automatic quiet();
        store_start = 0;
        store_stop  = 0;
    endtask

    task automatic drain_one();
        m_if.m_ready = 1;
        step();
        m_if.m_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int ready_pct;

    initial begin
        m_if.m_ready = 0;
        rst = 1;
        step(3);
        check("rst_fill", fill, 0);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_data", m_if.m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        rst = 0;
        step();

        // Start then stop five edges later; push lands five edges after stop.
        strobe(1, 0, 16'h0003, 16'h0000, 8'h00);
        step();
        check("t1_busy", busy, 1);
        quiet();
        step(4);
        strobe(0, 1, 16'h0000, 16'h00FF, 8'h12);
        step();
        quiet();
        step(4);
        check("t1_done_early", done, 0);
        check("t1_valid_early", m_if.m_valid, 0);
        step();
        check("t1_done", done, 1);
        check("t1_valid", m_if.m_valid, 1);
        check("t1_data", m_if.m_data, 40'h12_0003_00FF);
        check("t1_fill", fill, 1);
        step();
        check("t1_done_once", done, 0);
        drain_one();
        check("t1_drained", fill, 0);

        strobe(1, 1, 16'h0001, 16'h0002, 8'h00);
        step();
        quiet();
        step(SETTLE);
        check("t2_done_early", done, 0);
        step();
        check("t2_done", done, 1);
        check("t2_data", m_if.m_data, 40'h00_0001_0002);
        drain_one();

        strobe(1, 0, 16'h0055, 16'h0000, 8'h00);
        step();
        quiet();
        step(TMO - 1);
        check("t3_no_tmo", timeout, 0);
        check("t3_busy", busy, 1);
        step();
        check("t3_tmo", timeout, 1);
        check("t3_tmo_busy", busy, 0);
        check("t3_tmo_done", done, 0);
        check("t3_tmo_fill", fill, 0);
        step();
        check("t3_tmo_once", timeout, 0);
        check("t3_idle", busy, 0);

        // Stop arrives on the very edge the timeout would fire.
        strobe(1, 0, 16'h0066, 16'h0000, 8'h00);
        step();
        quiet();
        step(TMO - 1);
        strobe(0, 1, 16'h0000, 16'h0777, 8'h33);
        step();
        quiet();
        check("t3b_no_tmo", timeout, 0);
        check("t3b_busy", busy, 1);
        step(SETTLE + 1);
        check("t3b_done", done, 1);
        check("t3b_data", m_if.m_data, 40'h33_0066_0777);
        drain_one();

        m_if.m_ready = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            strobe(1, 1, 16'(16'h0100 + i), 16'(16'h0200 + i), 8'(i + 1));
            step();
            quiet();
            step(SETTLE + 1);
            check("t4_done", done, 1);
            if (i == DEPTH - 1) begin
                check("t4_fill_full", fill, DEPTH);
                check("t4_no_ovf_yet", overflow, 0);
            end
        end
        check("t4_fill", fill, DEPTH);
        check("t4_ovf", overflow, 1);
        m_if.m_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t4_order", m_if.m_data, {8'(i + 1), 16'(16'h0100 + i), 16'(16'h0200 + i)});
            step();
        end
        m_if.m_ready = 0;
        check("t4_empty", fill, 0);
        check("t4_ovf_sticky", overflow, 1);

        strobe(1, 1, 16'h0AAA, 16'h0BBB, 8'h44);
        step();
        quiet();
        step(2);
        rst = 1;
        step();
        rst = 0;
        check("t5_busy", busy, 0);
        check("t5_ovf", overflow, 0);
        check("t5_valid", m_if.m_valid, 0);
        check("t5_fill", fill, 0);
        for (int i = 0; i < SETTLE + 2; i++) begin
            step();
            check("t5_no_done", done, 0);
        end
        strobe(1, 1, 16'h1234, 16'h5678, 8'h9A);
        step();
        quiet();
        step(SETTLE + 1);
        check("t5_done", done, 1);
        check("t5_data", m_if.m_data, 40'h9A_1234_5678);
        drain_one();

        strobe(0, 1, 16'h0000, 16'h1111, 8'h22);
        step();
        quiet();
        check("t6_lone_stop", busy, 0);
        strobe(1, 0, 16'hAAAA, 16'h0000, 8'h00);
        step();
        strobe(1, 0, 16'hBBBB, 16'h0000, 8'h00);
        step();
        strobe(0, 1, 16'h0000, 16'h5555, 8'h77);
        step();
        strobe(1, 1, 16'hCCCC, 16'hDDDD, 8'h99);
        step(2);
        quiet();
        step(SETTLE - 1);
        check("t6_done", done, 1);
        check("t6_data", m_if.m_data, 40'h77_AAAA_5555);
        check("t6_fill", fill, 1);
        drain_one();

        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_pct = 10 * $urandom_range(0, 10);
            store_start  = ($urandom_range(0, 5) == 0);
            store_stop   = ($urandom_range(0, 4) == 0);
            start_code   = 16'($urandom);
            stop_code    = 16'($urandom);
            coarse       = 8'($urandom);
            m_if.m_ready = ($urandom_range(0, 99) < ready_pct);
            rst          = ($urandom_range(0, 599) == 0);
            step();
        end
        quiet();
        rst = 0;
        m_if.m_ready = 1;
        step(SETTLE + DEPTH + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
